// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared state encoding, width defaults and exponent-difference helper for the FP add controller
package fp_add_pkg;
  localparam int MENT_WIDTH_DEF = 23;
  localparam int EXPO_WIDTH_DEF = 8;
  localparam int MAX_ALIGN_DEF = MENT_WIDTH_DEF + 2;
  typedef enum logic [2:0] {IDLE, COMPARE, ALIGN, ADD, NORM, DONE} state_t;
  // d is exponent1 + two's-complement(exponent2) of width w+1; bit w set means exponent1 >= exponent2
  function automatic logic [31:0] exp_mag(input logic [31:0] d, input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return d[w] ? (d & mask) : ((~d + 32'd1) & mask);
  endfunction
endpackage

// File: rtl/fp_add_shift_counter.sv
// fp_add_shift_counter: loadable down-counter, load value saturated to MAX, stops at zero
//   clk, rst_n   clock, async active-low reset
//   load         load min(load_val, MAX)
//   dec          decrement by one (held at zero)
//   count, zero  current count and count==0 flag
module fp_add_shift_counter #(
  parameter int WIDTH = 5,
  parameter int MAX = 25,
  parameter int LW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LW-1:0]    load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);
  logic [WIDTH-1:0] sat;
  assign sat = (32'(load_val) > MAX) ? WIDTH'(MAX) : WIDTH'(load_val);
  assign zero = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= sat;
    else if (dec && !zero) count <= count - 1'b1;
endmodule

// File: rtl/fp_add_control_unit.sv
// fp_add_control_unit: sequencer for the FP add datapath (compare, align, add, normalize, handshake)
//   clk_in, rst_n_in             clock, async active-low reset
//   start_in / ready_out         request handshake, ready only in IDLE
//   exp_diff_in                  exponent difference, sampled in COMPARE only
//   mux1/2/3_sel_out             operand selects, held from COMPARE until back in IDLE
//   align_shift_out, add_en_out  alignment shift and mantissa add strobes
//   mant_carry_in, norm_msb_in, sum_zero_in   adder status
//   norm_right/left_out, exp_inc/dec_out      normalizer strobes
//   result_valid_out / result_ready_in, zero_out   result handshake
//   op_cycles_out                busy-cycle count, only with FP_ADD_CTRL_PERF_CNT_EN defined
module fp_add_control_unit import fp_add_pkg::*; #(
  parameter int MENT_WIDTH = MENT_WIDTH_DEF,
  parameter int EXPO_WIDTH = EXPO_WIDTH_DEF,
  parameter int MAX_ALIGN = MENT_WIDTH + 2
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
`ifdef FP_ADD_CTRL_PERF_CNT_EN
  output logic [7:0]          op_cycles_out,
`endif
  input  logic                start_in,
  output logic                ready_out,
  input  logic [EXPO_WIDTH:0] exp_diff_in,
  output logic                mux1_sel_out,
  output logic                mux2_sel_out,
  output logic                mux3_sel_out,
  output logic                align_shift_out,
  output logic                add_en_out,
  input  logic                mant_carry_in,
  input  logic                norm_msb_in,
  input  logic                sum_zero_in,
  output logic                norm_right_out,
  output logic                norm_left_out,
  output logic                exp_inc_out,
  output logic                exp_dec_out,
  output logic                result_valid_out,
  input  logic                result_ready_in,
  output logic                zero_out
);
  localparam int SW = $clog2(MAX_ALIGN + 1);
  localparam int NW = $clog2(MENT_WIDTH + 1);
  state_t state, next;
  logic sel_q, carry_q, zero_q, accept, shift_zero, norm_stop;
  logic [EXPO_WIDTH-1:0] mag;
  logic [SW-1:0] shift_cnt;
  logic [NW-1:0] norm_cnt;
  assign mag = EXPO_WIDTH'(exp_mag(32'(exp_diff_in), EXPO_WIDTH));
  assign accept = start_in && state == IDLE;
  assign norm_stop = carry_q || sum_zero_in || norm_msb_in;
  assign ready_out = state == IDLE;
  assign result_valid_out = state == DONE;
  assign zero_out = result_valid_out && zero_q;
  assign {mux1_sel_out, mux2_sel_out, mux3_sel_out} = {3{sel_q}};
  assign align_shift_out = state == ALIGN;
  assign add_en_out = state == ADD;
  assign norm_right_out = state == NORM && carry_q;
  assign norm_left_out = state == NORM && !norm_stop;
  assign exp_inc_out = norm_right_out;
  assign exp_dec_out = norm_left_out;
  fp_add_shift_counter #(.WIDTH(SW), .MAX(MAX_ALIGN), .LW(EXPO_WIDTH)) u_shift (
    .clk(clk_in), .rst_n(rst_n_in), .load(state == COMPARE), .load_val(mag),
    .dec(align_shift_out), .count(shift_cnt), .zero(shift_zero)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start_in ? COMPARE : IDLE;
      COMPARE: next = mag != '0 ? ALIGN : ADD;
      ALIGN:   next = (shift_zero || shift_cnt == SW'(1)) ? ADD : ALIGN;
      ADD:     next = NORM;
      NORM:    next = (norm_stop || norm_cnt == NW'(MENT_WIDTH - 1)) ? DONE : NORM;
      DONE:    next = result_ready_in ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      sel_q <= 1'b0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
      norm_cnt <= '0;
    end else begin
      state <= next;
      if (state == COMPARE) sel_q <= exp_diff_in[EXPO_WIDTH];
      else if (state == DONE && result_ready_in) sel_q <= 1'b0;
      if (state == ADD) carry_q <= mant_carry_in;
      if (accept) begin
        zero_q <= 1'b0;
        norm_cnt <= '0;
      end else if (state == NORM) begin
        zero_q <= !carry_q && sum_zero_in;
        if (norm_left_out) norm_cnt <= norm_cnt + 1'b1;
      end
    end
`ifdef FP_ADD_CTRL_PERF_CNT_EN
  logic busy;
  logic [7:0] perf_cnt, perf_nxt;
  assign busy = state != IDLE && state != DONE;
  assign perf_nxt = perf_cnt == 8'hFF ? perf_cnt : perf_cnt + 8'd1;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      perf_cnt <= '0;
      op_cycles_out <= '0;
    end else begin
      if (accept) perf_cnt <= '0;
      else if (busy) perf_cnt <= perf_nxt;
      if (busy && next == DONE) op_cycles_out <= perf_nxt;
    end
`endif
endmodule

// File: tb/tb_fp_add_control_unit.sv
// tb_fp_add_control_unit: vector table plus randomized operations checked against a pulse-count/latency model
module tb_fp_add_control_unit;
  logic clk = 0, rst_n = 0, start = 0, carry = 0, msb = 0, szero = 0, rready = 0;
  logic [8:0] diff = '0;
  logic ready, m1, m2, m3, align, add, nright, nleft, inc, dec, valid, zero;
`ifdef FP_ADD_CTRL_PERF_CNT_EN
  logic [7:0] op_cycles;
`endif
  int total = 0, passed = 0;

  fp_add_control_unit dut (
    .clk_in(clk), .rst_n_in(rst_n),
`ifdef FP_ADD_CTRL_PERF_CNT_EN
    .op_cycles_out(op_cycles),
`endif
    .start_in(start), .ready_out(ready), .exp_diff_in(diff),
    .mux1_sel_out(m1), .mux2_sel_out(m2), .mux3_sel_out(m3),
    .align_shift_out(align), .add_en_out(add), .mant_carry_in(carry),
    .norm_msb_in(msb), .sum_zero_in(szero), .norm_right_out(nright),
    .norm_left_out(nleft), .exp_inc_out(inc), .exp_dec_out(dec),
    .result_valid_out(valid), .result_ready_in(rready), .zero_out(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] diff; bit carry; bit szero; int m; int hold;
    bit ge; int k; int lefts; int rights; int lat; bit z;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t model(input int e1, input int e2, input bit c, input bit sz, input int m, input int hold);
    vec_t v;
    int d, nc;
    d = e1 - e2;
    v.diff = 9'(e1 + 256 - e2);
    v.carry = c;
    v.szero = sz;
    v.m = m;
    v.hold = hold;
    v.ge = e1 >= e2;
    v.k = (d < 0 ? -d : d) > 25 ? 25 : (d < 0 ? -d : d);
    v.rights = c;
    v.z = !c && sz;
    v.lefts = (c || sz) ? 0 : (m < 23 ? m : 23);
    nc = (c || sz) ? 1 : (m < 23 ? m + 1 : 23);
    v.lat = 2 + v.k + nc;
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int cyc, na, nadd, nl, nr, ni, nd, nrdy, held;
    {na, nadd, nl, nr, ni, nd, nrdy, held} = '0;
    start = 1; diff = v.diff; carry = v.carry; szero = v.szero; msb = (v.m == 0);
    @(posedge clk); #1 start = 0;
    #1 cyc = 0;
    while (!valid && cyc < 400) begin
      na += align; nadd += add; nl += nleft; nr += nright; ni += inc; nd += dec; nrdy += ready;
      @(posedge clk); #1;
      cyc++;
      diff = 9'($urandom);
      start = 1'($urandom_range(0, 1));
      msb = nl >= v.m;
      #1;
    end
    chk("latency", cyc, v.lat);
    chk("align_pulses", na, v.k);
    chk("add_pulses", nadd, 1);
    chk("norm_left_pulses", nl, v.lefts);
    chk("exp_dec_pulses", nd, v.lefts);
    chk("norm_right_pulses", nr, v.rights);
    chk("exp_inc_pulses", ni, v.rights);
    chk("ready_low_busy", nrdy, 0);
    chk("sels", {m1, m2, m3}, {3{v.ge}});
    chk("zero_out", zero, v.z);
    chk("done_strobes", {align, add, nright, nleft, inc, dec}, 0);
    for (int i = 0; i < v.hold; i++) begin
      start = 1;
      @(posedge clk); #2;
      held += (valid && zero == v.z && !ready);
    end
    chk("backpressure_hold", held, v.hold);
    start = 0; rready = 1;
    @(posedge clk); #1 rready = 0;
    #1 chk("release", {valid, ready}, 2'b01);
    @(posedge clk); #2 chk("no_queue", {ready, m1}, 2'b10);
  endtask

  vec_t tbl[6];

  initial begin
    #2_000_000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_ready", ready, 1);
    chk("reset_outs", {valid, zero, m1, m2, m3, align, add, nright, nleft, inc, dec}, 0);
    rst_n = 1;
    #1;
    tbl[0] = '{9'h102, 0, 0, 0, 0, 1, 2, 0, 0, 5, 0};
    tbl[1] = '{9'h0FD, 0, 0, 0, 1, 0, 3, 0, 0, 6, 0};
    tbl[2] = '{9'h100, 1, 0, 0, 0, 1, 0, 0, 1, 3, 0};
    tbl[3] = '{9'h1C8, 0, 0, 3, 2, 1, 25, 3, 0, 31, 0};
    tbl[4] = '{9'h100, 0, 1, 0, 6, 1, 0, 0, 0, 3, 1};
    tbl[5] = '{9'h100, 0, 0, 30, 0, 1, 0, 23, 0, 25, 0};
    for (int i = 0; i < 6; i++) run_op(tbl[i]);
    for (int i = 0; i < 40; i++)
      run_op(model($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0 ? 25 : $urandom_range(0, 5),
                   $urandom_range(0, 3)));
    begin
      int na = 0;
      start = 1; diff = 9'h1C8; carry = 0; szero = 0; msb = 1;
      @(posedge clk); #1 start = 0;
      for (int i = 0; i < 10 && na < 2; i++) begin
        @(posedge clk); #2;
        na += align;
      end
      chk("pre_reset_align", {na, align}, {32'd2, 1'b1});
      rst_n = 0;
      #1;
      chk("async_reset_ready", ready, 1);
      chk("async_reset_outs", {valid, zero, m1, m2, m3, align, add, nright, nleft, inc, dec}, 0);
      #2 rst_n = 1;
      #1;
      run_op(tbl[0]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
